// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: access-size selects, arbiter states and requester ids.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        F3_BYTE   = 3'b000,
        F3_HALF   = 3'b001,
        F3_WORD   = 3'b010,
        F3_BYTE_U = 3'b100,
        F3_HALF_U = 3'b101
    } mem_funct3_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_EXT  = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter onto a single synchronous memory port.
// Each access walks IDLE -> ISSUE -> RESP, so one access occupies three cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    // Handshake: a requester raises req with its fields and holds them until
    // it sees its one-cycle ack; rdata is valid in the ack cycle only.
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [2:0]        core_funct3,
    output logic              core_ack,
    output logic              core_stall,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [2:0]        ext_funct3,
    output logic              ext_ack,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,

    output arb_state_t        arb_state
);

    arb_state_t        state_q, state_d;
    req_id_t           last_q, last_d;
    req_id_t           gnt_q, gnt_d;
    req_id_t           pick;
    logic              grant_en;

    logic              we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [2:0]        mem_funct3_q;
    logic              mem_wren_q;
    logic [DATA_W-1:0] rdata_q;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        sel_funct3;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        pick = REQ_EXT;
        if (core_req && ext_req) begin
            pick = (last_q == REQ_EXT) ? REQ_CORE : REQ_EXT;
        end else if (core_req) begin
            pick = REQ_CORE;
        end
    end

    always_comb begin
        sel_we     = ext_we;
        sel_addr   = ext_addr;
        sel_wdata  = ext_wdata;
        sel_funct3 = ext_funct3;
        if (pick == REQ_CORE) begin
            sel_we     = core_we;
            sel_addr   = core_addr;
            sel_wdata  = core_wdata;
            sel_funct3 = core_funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        grant_en = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (core_req || ext_req) begin
                    grant_en = 1'b1;
                    gnt_d    = pick;
                    last_d   = pick;
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: state_d = ARB_RESP;
            ARB_RESP:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Fields are captured only at the grant edge; later changes on the request
    // lines do not reach the memory port.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q       <= REQ_EXT;
            gnt_q        <= REQ_CORE;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_funct3_q <= '0;
            mem_wren_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            mem_wren_q <= grant_en & sel_we;
            if (grant_en) begin
                we_q         <= sel_we;
                mem_addr_q   <= sel_addr;
                mem_wdata_q  <= sel_wdata;
                mem_funct3_q <= sel_funct3;
            end
            if (state_q == ARB_RESP && !we_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Outputs are forced low while reset is asserted so an aborted access can
    // neither ack nor write in the reset cycle itself.
    always_comb begin
        core_ack   = 1'b0;
        ext_ack    = 1'b0;
        rdata      = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = '0;
        mem_wren   = 1'b0;
        if (!reset) begin
            core_ack   = (state_q == ARB_RESP) && (gnt_q == REQ_CORE);
            ext_ack    = (state_q == ARB_RESP) && (gnt_q == REQ_EXT);
            rdata      = (state_q == ARB_RESP && !we_q) ? mem_rdata : rdata_q;
            mem_addr   = mem_addr_q;
            mem_wdata  = mem_wdata_q;
            mem_funct3 = mem_funct3_q;
            mem_wren   = mem_wren_q;
        end
    end

    assign core_stall = core_req & ~core_ack;
    assign arb_state  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus two random requesters, checked by a
// monitor against a word-level reference memory and per-requester expected queues.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TXN_W = 1 + 3 + AW + DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [2:0]    core_funct3 = '0;
    logic          ext_req = 1'b0, ext_we = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [DW-1:0] ext_wdata = '0;
    logic [2:0]    ext_funct3 = '0;
    logic          core_ack, core_stall, ext_ack, mem_wren;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_funct3;
    arb_state_t    arb_state;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_ack(core_ack), .core_stall(core_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_funct3(ext_funct3), .ext_ack(ext_ack),
        .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_wren(mem_wren), .mem_rdata(mem_rdata),
        .arb_state(arb_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    int core_acks = 0;
    int ext_acks = 0;
    logic [TXN_W-1:0] exp_core_q[$];
    logic [TXN_W-1:0] exp_ext_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_pat(input logic [7:0] idx);
        if (idx == 8'h40) return 32'hDEADBEEF;
        return {idx, ~idx, 8'h5A, idx ^ 8'h3C};
    endfunction

    // Memory model: one-cycle read latency, untouched words hold init_pat.
    logic [31:0] mem_arr [256];
    bit          mem_vld [256];
    always @(posedge clk) begin
        if (mem_wren) begin
            mem_arr[mem_addr[9:2]] <= mem_wdata;
            mem_vld[mem_addr[9:2]] <= 1'b1;
        end
        mem_rdata <= mem_vld[mem_addr[9:2]] ? mem_arr[mem_addr[9:2]] : init_pat(mem_addr[9:2]);
    end

    // Monitor: reference memory is updated in ack order, since accesses are serialized.
    initial begin : monitor
        logic [31:0]      ref_mem [256];
        logic [31:0]      model_rdata;
        logic             iss_seen;
        logic [TXN_W-1:0] iss;
        logic [TXN_W-1:0] e;
        logic [7:0]       idx;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_pat(i[7:0]);
        model_rdata = '0;
        iss_seen    = 1'b0;
        iss         = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_core_ack", core_ack, 0);
                chk("rst_ext_ack", ext_ack, 0);
                chk("rst_mem_wren", mem_wren, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_mem_funct3", mem_funct3, 0);
                chk("rst_rdata", rdata, 0);
                model_rdata = '0;
                iss_seen    = 1'b0;
            end else begin
                chk("ack_exclusive", core_ack & ext_ack, 0);
                chk("core_stall", core_stall, core_req & ~core_ack);
                if (arb_state == ARB_ISSUE) begin
                    iss      = {mem_wren, mem_funct3, mem_addr, mem_wdata};
                    iss_seen = 1'b1;
                end else begin
                    chk("wren_outside_issue", mem_wren, 0);
                end
                if (core_ack || ext_ack) begin
                    if (core_ack) core_acks++;
                    else ext_acks++;
                    if (core_ack ? (exp_core_q.size() == 0) : (exp_ext_q.size() == 0)) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_ack: got core_ack=%0b ext_ack=%0b required no ack at %0t",
                                 core_ack, ext_ack, $time);
                    end else begin
                        e   = core_ack ? exp_core_q.pop_front() : exp_ext_q.pop_front();
                        idx = e[41:34];
                        chk("issue_before_ack", iss_seen, 1);
                        chk("mem_wren", iss[67], e[67]);
                        chk("mem_funct3", iss[66:64], e[66:64]);
                        chk("mem_addr", iss[63:32], e[63:32]);
                        if (e[67]) begin
                            chk("mem_wdata", iss[31:0], e[31:0]);
                            chk("rdata_held_on_write", rdata, model_rdata);
                            ref_mem[idx] = e[31:0];
                        end else begin
                            chk("rdata", rdata, ref_mem[idx]);
                            model_rdata = ref_mem[idx];
                        end
                        iss_seen = 1'b0;
                    end
                end
            end
        end
    end

    // Drive one request, hold it until ack, then release; called at posedge+1.
    task automatic access(input bit ext, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [2:0] f3,
                          input int lat_lim, input bit exact);
        int lat;
        lat = 0;
        if (ext) begin
            exp_ext_q.push_back({we, f3, addr, wdata});
            ext_we = we; ext_addr = addr; ext_wdata = wdata; ext_funct3 = f3; ext_req = 1'b1;
        end else begin
            exp_core_q.push_back({we, f3, addr, wdata});
            core_we = we; core_addr = addr; core_wdata = wdata; core_funct3 = f3; core_req = 1'b1;
        end
        forever begin
            @(negedge clk);
            lat++;
            if (ext ? ext_ack : core_ack) break;
            if (lat >= 20) begin
                n_cmp++;
                n_err++;
                $display("FAIL ack_timeout: got no ack after %0d cycles required ack (ext=%0b)", lat, ext);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (ext) ext_req = 1'b0;
        else core_req = 1'b0;
        if (exact) chk(ext ? "ext_latency" : "core_latency", lat, lat_lim);
        else chk(ext ? "ext_latency_bound" : "core_latency_bound", lat <= lat_lim, 1);
    endtask

    task automatic rand_driver(input bit ext, input int n);
        logic [2:0] f3s [5];
        logic [7:0] idx;
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            idx = 8'($urandom_range(0, 255));
            access(ext, 1'($urandom_range(0, 1)), {22'd0, idx, 2'b00}, $urandom,
                   f3s[$urandom_range(0, 4)], 6, 1'b0);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000");
        $fatal(1);
    end

    initial begin : main
        int acks0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Held simultaneous requests from reset: core, ext, core, ext, 3 cycles apart.
        fork
            begin
                access(1'b0, 1'b0, 32'h10, '0, 3'b010, 3, 1'b1);
                access(1'b0, 1'b0, 32'h14, '0, 3'b010, 6, 1'b1);
            end
            begin
                access(1'b1, 1'b0, 32'h20, '0, 3'b010, 6, 1'b1);
                access(1'b1, 1'b0, 32'h24, '0, 3'b010, 6, 1'b1);
            end
        join

        // Core-only read of the preloaded word.
        access(1'b0, 1'b0, 32'h100, '0, 3'b010, 3, 1'b1);
        chk("rdata_0x100", rdata, 32'hDEADBEEF);

        // External word write.
        access(1'b1, 1'b1, 32'h40, 32'h12345678, 3'b010, 3, 1'b1);

        // Address change after grant must not reach the memory port.
        exp_core_q.push_back({1'b0, 3'b010, 32'h100, 32'h0});
        core_we = 1'b0; core_addr = 32'h100; core_wdata = '0; core_funct3 = 3'b010; core_req = 1'b1;
        @(posedge clk);
        #1 core_addr = 32'h200;
        @(negedge clk);
        chk("addr_latched", mem_addr, 32'h100);
        @(negedge clk);
        chk("late_change_ack", core_ack, 1);
        @(posedge clk);
        #1 core_req = 1'b0;

        // Core request withdrawn before it could be granted.
        acks0 = core_acks;
        fork
            access(1'b1, 1'b0, 32'h80, '0, 3'b010, 3, 1'b1);
            begin
                @(posedge clk);
                #1 core_req = 1'b1; core_addr = 32'h300; core_we = 1'b1;
                @(posedge clk);
                #1 core_req = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("withdrawn_no_ack", core_acks, acks0);
        @(posedge clk);
        #1;

        // Reset while a write is in ISSUE.
        acks0 = core_acks;
        core_we = 1'b1; core_addr = 32'h44; core_wdata = 32'hCAFEF00D; core_funct3 = 3'b010;
        core_req = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1; core_req = 1'b0;
        @(negedge clk);
        chk("abort_in_issue", arb_state, ARB_ISSUE);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_state_idle", arb_state, ARB_IDLE);
        repeat (3) @(negedge clk);
        chk("abort_no_ack", core_acks, acks0);
        @(posedge clk);
        #1;
        fork
            access(1'b0, 1'b0, 32'h44, '0, 3'b010, 3, 1'b1);
            access(1'b1, 1'b0, 32'h48, '0, 3'b010, 6, 1'b1);
        join

        // Random contention from both requesters.
        fork
            rand_driver(1'b0, 25);
            rand_driver(1'b1, 25);
        join

        repeat (5) @(posedge clk);
        chk("core_queue_drained", exp_core_q.size(), 0);
        chk("ext_queue_drained", exp_ext_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
